// File: rtl/isa_pkg.sv
// Shared ISA constants for the ARM-subset core: op codes, op classes and DP opcodes.
// The instruction decoder and the instruction encoder both import this package.
package isa_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_ORR   = 4'd3,
      OP_MUL   = 4'd4,
      OP_DIV   = 4'd5,
      OP_UMULL = 4'd6,
      OP_SMULL = 4'd7,
      OP_FADDS = 4'd8,
      OP_FMULS = 4'd9,
      OP_MOV   = 4'd10,
      OP_MOVT  = 4'd11,
      OP_MOVM  = 4'd12,
      OP_LDR   = 4'd13,
      OP_STR   = 4'd14,
      OP_B     = 4'd15
   } enc_op_t;

   localparam logic [1:0] CLASS_DP  = 2'b00;
   localparam logic [1:0] CLASS_MEM = 2'b01;
   localparam logic [1:0] CLASS_BR  = 2'b10;

   localparam logic [3:0] DP_ADD   = 4'b0100;
   localparam logic [3:0] DP_SUB   = 4'b0010;
   localparam logic [3:0] DP_AND   = 4'b0000;
   localparam logic [3:0] DP_ORR   = 4'b1100;
   localparam logic [3:0] DP_MUL   = 4'b1001;
   localparam logic [3:0] DP_DIV   = 4'b0001;
   localparam logic [3:0] DP_FLOAT = 4'b1000;
   localparam logic [3:0] DP_MOV   = 4'b1101;
   localparam logic [3:0] DP_MOVT  = 4'b1010;
   localparam logic [3:0] DP_MOVM  = 4'b1110;

   localparam logic [3:0] COND_AL = 4'hE;

   // Opcode field [24:21] for ops that use the data-processing layout.
   function automatic logic [3:0] dp_opcode(enc_op_t op);
      case (op)
         OP_ADD:             return DP_ADD;
         OP_SUB:             return DP_SUB;
         OP_ORR:             return DP_ORR;
         OP_MUL:             return DP_MUL;
         OP_DIV:             return DP_DIV;
         OP_FADDS, OP_FMULS: return DP_FLOAT;
         OP_MOV:             return DP_MOV;
         OP_MOVT:            return DP_MOVT;
         OP_MOVM:            return DP_MOVM;
         default:            return DP_AND;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and memory-write bundle of the instruction encoder.
// slave is the encoder's view; master is the requester/memory side.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic        in_s;
   logic        in_imm_en;
   logic [3:0]  in_rd;
   logic [3:0]  in_rn;
   logic [3:0]  in_rm;
   logic [3:0]  in_rs;
   logic [23:0] in_imm;
   logic        in_last;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;

   modport slave (
      input  in_valid, in_op, in_s, in_imm_en, in_rd, in_rn, in_rm, in_rs, in_imm, in_last,
      input  mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_op, in_s, in_imm_en, in_rd, in_rn, in_rm, in_rs, in_imm, in_last,
      output mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder_encode_word.sv
// Combinational field-to-word encoder; flags requests whose fields cannot be encoded.
module encode_word
   import isa_pkg::*;
(
   input  logic [3:0]  op,
   input  logic        s,
   input  logic        imm_en,
   input  logic [3:0]  rd,
   input  logic [3:0]  rn,
   input  logic [3:0]  rm,
   input  logic [3:0]  rs,
   input  logic [23:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   enc_op_t op_e;
   logic    imm_hi12;
   logic    imm_hi8;

   assign op_e     = enc_op_t'(op);
   assign imm_hi12 = |imm[23:12];
   assign imm_hi8  = |imm[23:16];

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op_e)
         OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MUL, OP_DIV: begin
            word    = {COND_AL, CLASS_DP, imm_en, dp_opcode(op_e), s, rn, rd,
                       imm_en ? imm[11:0] : {8'h00, rm}};
            // MUL/DIV have no immediate form at all.
            illegal = imm_en && (imm_hi12 || op_e == OP_MUL || op_e == OP_DIV);
         end
         OP_UMULL, OP_SMULL: begin
            word    = {COND_AL, 5'b00001, op_e == OP_SMULL, 1'b0, s, rs, rd, rm, 4'b1001, rn};
            illegal = imm_en;
         end
         OP_FADDS, OP_FMULS: begin
            word    = {COND_AL, CLASS_DP, 1'b0, DP_FLOAT, s, rn, rd, 7'd0, op_e == OP_FMULS, rm};
            illegal = imm_en;
         end
         OP_MOV, OP_MOVT, OP_MOVM: begin
            word    = {COND_AL, CLASS_DP, 1'b1, dp_opcode(op_e), s, imm[15:12], rd, imm[11:0]};
            illegal = imm_hi8;
         end
         OP_LDR, OP_STR: begin
            // I=0 P=1 U=1 B=0 W=0, then L.
            word    = {COND_AL, CLASS_MEM, 5'b01100, op_e == OP_LDR, rn, rd, imm[11:0]};
            illegal = imm_hi12;
         end
         OP_B: begin
            word = {COND_AL, CLASS_BR, 2'b10, imm};
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction writer: encodes field-level requests and streams the words into
// instruction memory at consecutive addresses through a 2-entry FIFO.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        base_addr,
   instr_encoder_if.slave     bus,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [15:0]        words_written
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fifo_mem [FIFO_DEPTH];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic [31:0] addr;
   logic [31:0] word;
   logic        illegal;
   logic        accept;
   logic        push;
   logic        pop;

   encode_word u_encode (
      .op      (bus.in_op),
      .s       (bus.in_s),
      .imm_en  (bus.in_imm_en),
      .rd      (bus.in_rd),
      .rn      (bus.in_rn),
      .rm      (bus.in_rm),
      .rs      (bus.in_rs),
      .imm     (bus.in_imm),
      .word    (word),
      .illegal (illegal)
   );

   // Readiness uses the pre-pop count, so a full FIFO refuses input even while draining.
   assign bus.in_ready  = (state == RUN) && (count < 2'(FIFO_DEPTH));
   assign accept        = bus.in_valid && bus.in_ready;
   assign push          = accept && !illegal;
   assign bus.mem_we    = (count != 2'd0);
   assign pop           = bus.mem_we && bus.mem_ready;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = bus.mem_we ? fifo_mem[rd_ptr] : 32'd0;
   assign busy          = (state != IDLE);

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN:   if (accept && bus.in_last) state_nxt = DRAIN;
         DRAIN: if (count == 2'd0) begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         count         <= 2'd0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         addr          <= 32'd0;
         err           <= 1'b0;
         words_written <= 16'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            addr          <= base_addr;
            words_written <= 16'd0;
            err           <= 1'b0;
         end
         if (accept && illegal) err <= 1'b1;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr        <= ~rd_ptr;
            addr          <= addr + 32'd4;
            words_written <= words_written + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= word;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Programmable instruction writer for the multi-cycle ARM-subset core: the encode-direction counterpart of the instruction decoder. It accepts field-level instruction requests over a valid/ready handshake and encodes each into the exact 32-bit word format the decoder expects, including the UMULL/SMULL, FADDS/FMULS and MOV/MOVT/MOVM extensions. It buffers encoded words in a 2-entry FIFO and writes them to instruction memory at consecutive word addresses. It is used by the boot/program-load path and by the test harness to build programs in memory.

## Interface
Parameters:
- `FIFO_DEPTH`, 2, encoded-word buffer entries; fixed at 2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin a load session (honoured only in IDLE)
- `base_addr`  in  32  first write address, latched on `start`
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_op`  in  4  operation code (`enc_op_t`)
- `in_s`  in  1  set-flags bit
- `in_imm_en`  in  1  immediate operand form, data-processing ops
- `in_rd`, `in_rn`, `in_rm`, `in_rs`  in  4 each  register fields
- `in_imm`  in  24  immediate / branch offset
- `in_last`  in  1  final request of the session
- `mem_we`  out  1  write request
- `mem_addr`  out  32  write address
- `mem_wdata`  out  32  encoded word
- `mem_ready`  in  1  memory accepts the write this cycle
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle end-of-session pulse
- `err`  out  1  sticky error, cleared on `start`
- `words_written`  out  16  completed writes this session

## Operation
- Condition field [31:28] is always 1110.
- States:
  - IDLE: `start` → RUN. Latch `base_addr`; clear `words_written` and `err`.
  - RUN: `in_ready` = FIFO count < 2. An accepted request with `in_last` → DRAIN.
  - DRAIN: `in_ready`=0. When the FIFO is empty, pulse `done` and go to IDLE.
  - `start` outside IDLE is ignored.
- Encoding by `in_op`:
  - 0–5 ADD/SUB/AND/ORR/MUL/DIV: Op=00, opcodes 0100/0010/0000/1100/1001/0001; I=`in_imm_en`, S, Rn, Rd. [11:0] is `in_imm[11:0]` when I=1, else {8'h00, Rm}.
  - 6/7 UMULL/SMULL: [27:23]=00001, [22]=signed, [21]=0, S. [19:16]=`in_rs` (RdHi), [15:12]=`in_rd` (RdLo), [11:8]=Rm, [7:4]=1001, [3:0]=Rn.
  - 8/9 FADDS/FMULS: Op=00, I=0, opcode 1000, S, Rn, Rd, [11:5]=0, [4]=0/1, [3:0]=Rm.
  - 10/11/12 MOV/MOVT/MOVM: Op=00, I=1, opcodes 1101/1010/1110, S. [19:16]=imm[15:12], Rd, [11:0]=imm[11:0].
  - 13/14 LDR/STR: [27:20]=0101100L with L=1 for LDR, then Rn, Rd, imm12.
  - 15 B: [27:24]=1010, [23:0]=`in_imm`.
- Error conditions. An accepted request is discarded (not pushed) and `err` is set when any of these hold:
  - MOV/MOVT/MOVM with `in_imm[23:16]` nonzero.
  - Immediate DP op, LDR or STR with `in_imm[23:12]` nonzero.
  - MUL, DIV, long-multiply or float op with `in_imm_en`=1.
  
  An errored request that carries `in_last` still ends the session.
- FIFO head drives `mem_we`/`mem_addr`/`mem_wdata`. It pops on `mem_we && mem_ready`; each pop adds 4 to the address and 1 to `words_written`.
- Push and pop in the same cycle are legal at any count. `in_ready` is computed from the count before the pop, so a full FIFO refuses input even while it pops.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Latency: a request accepted at edge N appears on `mem_we` in cycle N+1 at the earliest.
- While `mem_we && !mem_ready`, `mem_addr` and `mem_wdata` hold stable.
- Address wraps modulo 2^32; `words_written` wraps modulo 2^16.
- `done` is high for exactly the one cycle in which DRAIN sees an empty FIFO.
- Reset asserted mid-session: the next cycle shows reset values, and buffered words are never written.

## Structure
- Shared package `isa_pkg` holds:
  - `enc_op_t` (the 16 op codes above).
  - Op-class constants (00/01/10).
  - DP opcode constants: ADD, SUB, AND, ORR, MUL, DIV, FLOAT=1000, MOV, MOVT, MOVM.
  - `COND_AL`=4'hE.
  - These are the same constants the decoder uses.
- Sub-module `encode_word`: combinational; request fields in, {word, illegal} out.
- FIFO and FSM live in the top module.

## Test plan
- `start` with base 0x100, then ADD rd=1 rn=2 rm=3 s=0 last → one write: addr 0x100, data 0xE0821003; `done` pulse; `words_written`=1.
- MOV rd=4 imm=0x1234 → data 0xE3A14234.
- UMULL rd=0 rs=1 rm=2 rn=3 → 0xE0810293. LDR rd=1 rn=2 imm=8 → 0xE5921008.
- Three requests with `mem_ready` low for 3 cycles:
  - `in_ready` drops after 2 are buffered.
  - `mem_addr` holds 0x100 while stalled.
  - Writes occur at 0x100, 0x104, 0x108 in order.
- MOV imm=0x10000 → `err`=1 and no write. A following B imm=0x10 last → 0xEA000010 at base; `err` stays 1.
- Reset low while the FIFO holds 2 words → next cycle `mem_we`=0, `busy`=0, `words_written`=0, and no further writes occur.
